// File: rtl/lpddr5_bank_timing_model_if.sv
// Command/data bundle between a memory controller and the LPDDR5 model.
// master = controller side, slave = device model side.
//
// Ports (all signals, direction as seen by the slave):
//   cmd_valid, cmd_op, cmd_bank, cmd_row, cmd_col  in   command bus
//   cmd_ready                                      out  command accepted
//   wdata  in / wready out                              write beat stream
//   rdata, rvalid                                  out  read beat stream
//   cmd_err, err_code                              out  illegal-command pulse
//   bank_open                                      out  per-bank ACTIVE flags
interface lpddr5_bank_timing_model_if #(
    parameter int CHANNELS  = 2,
    parameter int BANKS     = 16,
    parameter int ROW_BITS  = 16,
    parameter int COL_BITS  = 10,
    parameter int DATA_BITS = 32
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int DW = CHANNELS * DATA_BITS;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [BW-1:0]       cmd_bank;
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;
    logic                wready;
    logic [DW-1:0]       wdata;
    logic                rvalid;
    logic [DW-1:0]       rdata;
    logic                cmd_err;
    logic [2:0]          err_code;
    logic [BANKS-1:0]    bank_open;

    modport master (
        output cmd_valid, cmd_op, cmd_bank, cmd_row, cmd_col, wdata,
        input  cmd_ready, wready, rvalid, rdata, cmd_err, err_code,
        input  bank_open
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bank, cmd_row, cmd_col, wdata,
        output cmd_ready, wready, rvalid, rdata, cmd_err, err_code,
        output bank_open
    );
endinterface

// File: rtl/lpddr5_bank_timing_model.sv
// Behavioural LPDDR5 bank/timing model: per-bank state and timers,
// illegal-command detection, one burst in flight, CL-accurate reads.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  slave side of lpddr5_bank_timing_model_if (command, data,
//        error and bank_open signals)
module lpddr5_bank_timing_model #(
    parameter int CHANNELS  = 2,
    parameter int BANKS     = 16,
    parameter int ROW_BITS  = 16,
    parameter int COL_BITS  = 10,
    parameter int DATA_BITS = 32,
    parameter int BURST_LEN = 16,
    parameter int MEM_AW    = 14,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RAS     = 8,
    parameter int T_WR      = 6,
    parameter int CL        = 6,
    parameter int T_RFC     = 20
) (
    input logic clk,
    input logic rst,
    lpddr5_bank_timing_model_if.slave bus
);
    localparam int BW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int AW  = BW + ROW_BITS + COL_BITS;
    localparam int CW  = 8;
    localparam int BCW = 16;

    // A timer loaded with T-1 reads zero exactly T cycles after the
    // command edge, so the command becomes legal at cycle n+T.
    localparam logic [CW-1:0] LD_RCD = CW'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CW-1:0] LD_RP  = CW'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [CW-1:0] LD_RAS = CW'((T_RAS > 0) ? T_RAS - 1 : 0);
    localparam logic [CW-1:0] LD_WR  = CW'((T_WR  > 0) ? T_WR  - 1 : 0);

    localparam logic [BCW-1:0] C_CL   = BCW'(CL);
    localparam logic [BCW-1:0] C_BL   = BCW'(BURST_LEN);
    localparam logic [BCW-1:0] C_RDE  = BCW'(CL + BURST_LEN - 1);
    localparam logic [BCW-1:0] C_RFC  = BCW'(T_RFC);

    typedef enum logic {
        B_IDLE,
        B_ACTIVE
    } bank_st_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_REF
    } burst_st_e;

    typedef struct packed {
        bank_st_e            st;
        logic [ROW_BITS-1:0] row;
        logic [CW-1:0]       rcd;
        logic [CW-1:0]       ras;
        logic [CW-1:0]       rp;
        logic [CW-1:0]       wr;
    } bank_t;

    bank_t               bank_q [BANKS];
    bank_t               sel;
    burst_st_e           st_q, st_d;
    logic [BCW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]       b_bank_q;
    logic [ROW_BITS-1:0] b_row_q;
    logic [COL_BITS-1:0] b_col_q;
    logic                err_q;
    logic [2:0]          code_q;
    logic [2:0]          code;

    logic op_act, op_rd, op_wr, op_pre, op_ref;
    logic acc, legal, any_open, any_rp;

    logic [BCW-1:0]      beat;
    logic [COL_BITS-1:0] col;
    logic [AW-1:0]       full;
    logic [MEM_AW-1:0]   maddr;
    logic                rvalid_w;

    logic [DATA_BITS-1:0] mem [CHANNELS][2**MEM_AW];

    assign op_act = (bus.cmd_op == 3'd1);
    assign op_rd  = (bus.cmd_op == 3'd2);
    assign op_wr  = (bus.cmd_op == 3'd3);
    assign op_pre = (bus.cmd_op == 3'd4);
    assign op_ref = (bus.cmd_op == 3'd5);

    assign acc = bus.cmd_valid && bus.cmd_ready &&
                 (op_act || op_rd || op_wr || op_pre || op_ref);
    assign sel   = bank_q[bus.cmd_bank];
    assign legal = acc && (code == 3'd0);

    always_comb begin
        any_open = 1'b0;
        any_rp   = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            any_open = any_open | (bank_q[b].st == B_ACTIVE);
            any_rp   = any_rp | (bank_q[b].rp != '0);
        end
    end

    always_comb begin
        code = 3'd0;
        unique case (1'b1)
            op_act: begin
                if (sel.st == B_ACTIVE || sel.rp != '0)
                    code = 3'd1;
            end
            op_rd, op_wr: begin
                if (sel.st == B_IDLE)
                    code = 3'd2;
                else if (sel.rcd != '0)
                    code = 3'd3;
            end
            op_pre: begin
                if (sel.ras != '0 || sel.wr != '0)
                    code = 3'd4;
            end
            op_ref: begin
                if (any_open || any_rp)
                    code = 3'd5;
            end
            default: code = 3'd0;
        endcase
    end

    // cnt_q is the cycle offset from the accepting edge: cycle n+cnt_q.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (st_q != S_IDLE)
            cnt_d = cnt_q + 1'b1;
        unique case (st_q)
            S_IDLE: begin
                if (legal && (op_rd || op_wr || op_ref)) begin
                    st_d  = op_rd ? S_RD : (op_wr ? S_WR : S_REF);
                    cnt_d = BCW'(1);
                end
            end
            S_RD: begin
                if (cnt_q == C_RDE) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            end
            S_WR: begin
                if (cnt_q == C_BL) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            end
            S_REF: begin
                if (cnt_q == C_RFC) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d  = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= 3'd0;
            b_bank_q <= '0;
            b_row_q  <= '0;
            b_col_q  <= '0;
            for (int b = 0; b < BANKS; b++)
                bank_q[b] <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            err_q  <= acc && (code != 3'd0);
            code_q <= (acc && (code != 3'd0)) ? code : 3'd0;

            for (int b = 0; b < BANKS; b++) begin
                if (bank_q[b].rcd != '0)
                    bank_q[b].rcd <= bank_q[b].rcd - 1'b1;
                if (bank_q[b].ras != '0)
                    bank_q[b].ras <= bank_q[b].ras - 1'b1;
                if (bank_q[b].rp != '0)
                    bank_q[b].rp <= bank_q[b].rp - 1'b1;
                if (bank_q[b].wr != '0)
                    bank_q[b].wr <= bank_q[b].wr - 1'b1;
            end

            // Write recovery starts on the edge sampling the last beat.
            if (st_q == S_WR && cnt_q == C_BL)
                bank_q[b_bank_q].wr <= LD_WR;

            if (legal) begin
                unique case (1'b1)
                    op_act: begin
                        bank_q[bus.cmd_bank].st  <= B_ACTIVE;
                        bank_q[bus.cmd_bank].row <= bus.cmd_row;
                        bank_q[bus.cmd_bank].rcd <= LD_RCD;
                        bank_q[bus.cmd_bank].ras <= LD_RAS;
                    end
                    op_rd, op_wr: begin
                        b_bank_q <= bus.cmd_bank;
                        b_row_q  <= sel.row;
                        b_col_q  <= bus.cmd_col;
                    end
                    op_pre: begin
                        if (sel.st == B_ACTIVE) begin
                            bank_q[bus.cmd_bank].st <= B_IDLE;
                            bank_q[bus.cmd_bank].rp <= LD_RP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read beat 0 lands at cnt==CL, write beat 0 at cnt==1.
    assign beat  = (st_q == S_RD) ? (cnt_q - C_CL) : (cnt_q - 1'b1);
    assign col   = b_col_q + COL_BITS'(beat);
    assign full  = {b_bank_q, b_row_q, col};
    assign maddr = MEM_AW'(full);

    assign rvalid_w = (st_q == S_RD) && (cnt_q >= C_CL);

    always_ff @(posedge clk) begin
        if (!rst && st_q == S_WR) begin
            for (int c = 0; c < CHANNELS; c++)
                mem[c][maddr] <= bus.wdata[c*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (rvalid_w) begin
            for (int c = 0; c < CHANNELS; c++)
                bus.rdata[c*DATA_BITS +: DATA_BITS] = mem[c][maddr];
        end
    end

    always_comb begin
        bus.bank_open = '0;
        for (int b = 0; b < BANKS; b++)
            bus.bank_open[b] = (bank_q[b].st == B_ACTIVE);
    end

    assign bus.cmd_ready = (st_q == S_IDLE);
    assign bus.wready    = (st_q == S_WR);
    assign bus.rvalid    = rvalid_w;
    assign bus.cmd_err   = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_lpddr5_bank_timing_model.sv
// Directed bench for lpddr5_bank_timing_model: timing legality,
// burst streaming, address wrap, refresh and mid-burst reset.
module tb_lpddr5_bank_timing_model;
    localparam int CH   = 2;
    localparam int NB   = 16;
    localparam int RB   = 16;
    localparam int CB   = 10;
    localparam int DB   = 32;
    localparam int BL   = 16;
    localparam int CL   = 6;
    localparam int TRFC = 20;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ACT = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_WR  = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4;
    localparam logic [2:0] OP_REF = 3'd5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    logic [63:0] ref_mem [int];

    lpddr5_bank_timing_model_if #(
        .CHANNELS(CH), .BANKS(NB), .ROW_BITS(RB),
        .COL_BITS(CB), .DATA_BITS(DB)
    ) dif ();

    lpddr5_bank_timing_model #(
        .CHANNELS(CH), .BANKS(NB), .ROW_BITS(RB),
        .COL_BITS(CB), .DATA_BITS(DB), .BURST_LEN(BL),
        .MEM_AW(14), .T_RCD(4), .T_RP(4), .T_RAS(8),
        .T_WR(6), .CL(CL), .T_RFC(TRFC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always @(negedge clk)
        if (dif.cmd_err === 1'b1) err_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int key(input int b, input int r, input int c);
        return (b << 26) | (r << 10) | (c & 1023);
    endfunction

    // Drives one command for one cycle; returns in cycle n+1.
    task automatic issue(input logic [2:0] op, input int b,
                         input int r, input int c);
        dif.cmd_valid = 1'b1;
        dif.cmd_op    = op;
        dif.cmd_bank  = 4'(b);
        dif.cmd_row   = 16'(r);
        dif.cmd_col   = 10'(c);
        tick();
        dif.cmd_valid = 1'b0;
        dif.cmd_op    = OP_NOP;
    endtask

    task automatic wr_burst(input int b, input int r, input int c,
                            input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] h, l;
        issue(OP_WR, b, r, c);
        chk("wr_accept_err", dif.cmd_err, 0);
        for (int i = 0; i < BL; i++) begin
            h = hi + 32'(i);
            l = lo + 32'(i);
            chk($sformatf("wready_b%0d", i), dif.wready, 1);
            if (i == 0) chk("wr_busy", dif.cmd_ready, 0);
            dif.wdata = {h, l};
            ref_mem[key(b, r, c + i)] = {h, l};
            tick();
        end
        dif.wdata = '0;
        chk("wready_end", dif.wready, 0);
        chk("wr_ready_back", dif.cmd_ready, 1);
    endtask

    task automatic rd_burst(input int b, input int r, input int c,
                            input bit data_chk);
        logic ev;
        int   k2;
        issue(OP_RD, b, r, c);
        chk("rd_accept_err", dif.cmd_err, 0);
        for (int k = 1; k <= CL + BL; k++) begin
            ev = (k >= CL) && (k < CL + BL);
            chk($sformatf("rvalid_k%0d", k), dif.rvalid, ev);
            k2 = key(b, r, c + k - CL);
            if (ev && data_chk && ref_mem.exists(k2))
                chk($sformatf("rdata_b%0d", k - CL), dif.rdata, ref_mem[k2]);
            if (k == CL + BL - 1) chk("rd_busy_last", dif.cmd_ready, 0);
            if (k == CL + BL) chk("rd_ready_back", dif.cmd_ready, 1);
            if (k < CL + BL) tick();
        end
    endtask

    initial begin
        rst           = 1'b1;
        dif.cmd_valid = 1'b0;
        dif.cmd_op    = OP_NOP;
        dif.cmd_bank  = '0;
        dif.cmd_row   = '0;
        dif.cmd_col   = '0;
        dif.wdata     = '0;
        idle(2);
        chk("rst_cmd_ready", dif.cmd_ready, 1);
        chk("rst_wready", dif.wready, 0);
        chk("rst_rvalid", dif.rvalid, 0);
        chk("rst_rdata", dif.rdata, 0);
        chk("rst_cmd_err", dif.cmd_err, 0);
        chk("rst_err_code", dif.err_code, 0);
        chk("rst_bank_open", dif.bank_open, 0);
        rst = 1'b0;
        err_pulses = 0;

        // 1: ACT, WR at +T_RCD, read back written beats
        issue(OP_ACT, 3, 'h12, 0);
        chk("t1_open3", dif.bank_open, 16'h0008);
        idle(3);
        wr_burst(3, 'h12, 0, 32'h100, 32'h200);
        rd_burst(3, 'h12, 0, 1'b1);
        chk("t1_no_err", 64'(err_pulses), 0);

        // 2: RD before tRCD rejected, RD at +T_RCD accepted
        issue(OP_ACT, 0, 'h5, 0);
        idle(1);
        issue(OP_RD, 0, 0, 0);
        chk("t2_err", dif.cmd_err, 1);
        chk("t2_code", dif.err_code, 3);
        chk("t2_no_rvalid", dif.rvalid, 0);
        chk("t2_ready", dif.cmd_ready, 1);
        idle(1);
        chk("t2_err_pulse", dif.cmd_err, 0);
        rd_burst(0, 'h5, 0, 1'b0);

        // 3: tRAS and tRP enforcement on bank 1
        issue(OP_ACT, 1, 'h9, 0);
        idle(2);
        issue(OP_PRE, 1, 0, 0);
        chk("t3_pre3_err", dif.cmd_err, 1);
        chk("t3_pre3_code", dif.err_code, 4);
        chk("t3_still_open", dif.bank_open[1], 1);
        idle(3);
        issue(OP_PRE, 1, 0, 0);
        chk("t3_pre7_code", dif.err_code, 4);
        issue(OP_PRE, 1, 0, 0);
        chk("t3_pre8_err", dif.cmd_err, 0);
        chk("t3_closed", dif.bank_open[1], 0);
        idle(1);
        issue(OP_ACT, 1, 'h9, 0);
        chk("t3_act2_err", dif.cmd_err, 1);
        chk("t3_act2_code", dif.err_code, 1);
        idle(1);
        issue(OP_ACT, 1, 'h9, 0);
        chk("t3_act4_err", dif.cmd_err, 0);
        chk("t3_reopen", dif.bank_open[1], 1);

        // 4: column wrap at 1023 -> 0
        issue(OP_ACT, 2, 'h34, 0);
        idle(3);
        wr_burst(2, 'h34, 1020, 32'hA00, 32'hB00);
        rd_burst(2, 'h34, 1020, 1'b1);
        rd_burst(2, 'h34, 0, 1'b1);

        // 5: refresh legality and duration
        issue(OP_ACT, 4, 'h7, 0);
        issue(OP_REF, 0, 0, 0);
        chk("t5_ref_open_err", dif.cmd_err, 1);
        chk("t5_ref_open_code", dif.err_code, 5);
        idle(6);
        for (int b = 0; b < 5; b++) begin
            issue(OP_PRE, (b + 4) % 5, 0, 0);
            chk($sformatf("t5_pre%0d_err", (b + 4) % 5), dif.cmd_err, 0);
        end
        chk("t5_all_closed", dif.bank_open, 0);
        issue(OP_REF, 0, 0, 0);
        chk("t5_ref_rp_code", dif.err_code, 5);
        idle(2);
        issue(OP_REF, 0, 0, 0);
        chk("t5_ref_err", dif.cmd_err, 0);
        chk("t5_ref_busy", dif.cmd_ready, 0);
        idle(TRFC - 1);
        chk("t5_ref_busy_last", dif.cmd_ready, 0);
        tick();
        chk("t5_ref_done", dif.cmd_ready, 1);

        // 6: reset during read beat 5, memory retained
        issue(OP_ACT, 3, 'h12, 0);
        idle(3);
        issue(OP_RD, 3, 0, 0);
        idle(CL + 4);
        chk("t6_beat5_valid", dif.rvalid, 1);
        chk("t6_beat5_data", dif.rdata, ref_mem[key(3, 'h12, 5)]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rvalid", dif.rvalid, 0);
        chk("t6_ready", dif.cmd_ready, 1);
        chk("t6_open", dif.bank_open, 0);
        chk("t6_err", dif.cmd_err, 0);
        tick();
        chk("t6_no_beat", dif.rvalid, 0);
        issue(OP_ACT, 3, 'h12, 0);
        idle(3);
        rd_burst(3, 'h12, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
